// File: rtl/data_memory_ctrl.sv
// Byte-addressable big-endian data memory for the MEM stage.
// Sized loads/stores, optional wait states, alignment/range flags.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        misaligned,
    output logic        out_of_range
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    // With no wait states the access happens at the accept edge,
    // so it works directly from the live request inputs.
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    localparam logic [3:0] WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [32:0] DEPTH_33 = 33'(DEPTH_BYTES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [3:0]  count;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        write_q;

    logic [7:0]  mem [DEPTH_BYTES];

    logic        req;
    logic        accept;
    logic        do_access;

    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic        op_write;

    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        bad_align;
    logic        bad_range;
    logic        legal;

    logic [AW-1:0] base;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] load_val;
    logic        sign_b;
    logic        sign_h;

    assign req    = memread | memwrite;
    assign accept = (state == S_IDLE) && req;

    // Select between live inputs and the captured request.
    always_comb begin
        if (NO_WAIT) begin
            op_addr     = addr;
            op_wdata    = write_data;
            op_size     = size;
            op_unsigned = load_unsigned;
            op_write    = memwrite;
            do_access   = accept;
        end else begin
            op_addr     = addr_q;
            op_wdata    = wdata_q;
            op_size     = size_q;
            op_unsigned = unsigned_q;
            op_write    = write_q;
            do_access   = (state == S_WAIT) && (count == 4'd0);
        end
    end

    // Access width and legality of the operation being performed.
    always_comb begin
        nbytes    = 3'd4;
        bad_align = 1'b0;
        unique case (op_size)
            2'b00: begin
                nbytes    = 3'd1;
                bad_align = 1'b0;
            end
            2'b01: begin
                nbytes    = 3'd2;
                bad_align = op_addr[0];
            end
            2'b10: begin
                nbytes    = 3'd4;
                bad_align = (op_addr[1:0] != 2'b00);
            end
            default: begin
                nbytes    = 3'd4;
                bad_align = 1'b1;
            end
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    assign last_byte = {1'b0, op_addr} + {30'd0, nbytes} - 33'd1;
    assign bad_range = (last_byte >= DEPTH_33);
    assign legal     = !bad_align && !bad_range;

    assign base = op_addr[AW-1:0];
    assign b0   = mem[base];
    assign b1   = mem[base + AW'(1)];
    assign b2   = mem[base + AW'(2)];
    assign b3   = mem[base + AW'(3)];

    assign sign_b = !op_unsigned && b0[7];
    assign sign_h = !op_unsigned && b0[7];

    // Big-endian assembly and extension of the loaded value.
    always_comb begin
        load_val = 32'd0;
        unique case (op_size)
            2'b00:   load_val = {{24{sign_b}}, b0};
            2'b01:   load_val = {{16{sign_h}}, b0, b1};
            2'b10:   load_val = {b0, b1, b2, b3};
            default: load_val = 32'd0;
        endcase
    end

    // Byte-lane writes for legal stores; the array itself is not reset.
    always_ff @(posedge clk) begin
        if (!rst && do_access && op_write && legal) begin
            unique case (op_size)
                2'b00: begin
                    mem[base] <= op_wdata[7:0];
                end
                2'b01: begin
                    mem[base]          <= op_wdata[15:8];
                    mem[base + AW'(1)] <= op_wdata[7:0];
                end
                2'b10: begin
                    mem[base]          <= op_wdata[31:24];
                    mem[base + AW'(1)] <= op_wdata[23:16];
                    mem[base + AW'(2)] <= op_wdata[15:8];
                    mem[base + AW'(3)] <= op_wdata[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Request FSM with wait counter and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            read_data    <= 32'd0;
            ready        <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            ready        <= do_access;
            misaligned   <= do_access && bad_align;
            out_of_range <= do_access && bad_range;

            if (do_access && !op_write && legal) begin
                read_data <= load_val;
            end

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q     <= addr;
                        wdata_q    <= write_data;
                        size_q     <= size;
                        unsigned_q <= load_unsigned;
                        write_q    <= memwrite;
                        if (!NO_WAIT) begin
                            state <= S_WAIT;
                            count <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl with two wait states.
// Byte-array reference model; monitor checks every ready pulse.
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] read_data;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH_BYTES(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .write_data(write_data),
        .memread(memread),
        .memwrite(memwrite),
        .size(size),
        .load_unsigned(load_unsigned),
        .read_data(read_data),
        .ready(ready),
        .misaligned(misaligned),
        .out_of_range(out_of_range)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        oor;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mdl [DEPTH];
    logic [31:0] mdl_rd;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     n, act, exp, $time);
        end
    endtask

    // Reference: access described as a list of bytes, MSB first.
    task automatic model_req(input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input logic lu,
                             input int stamp);
        exp_t        e;
        int          nb;
        logic        mis;
        logic        oor;
        logic [31:0] v;
        nb  = 1 << sz;
        mis = (sz == 2'd3) || ((a % nb) != 0);
        oor = ({32'd0, a} + 64'(nb) - 64'd1) >= 64'(DEPTH);
        if (!mis && !oor) begin
            if (w) begin
                for (int i = 0; i < nb; i++)
                    mdl[a + i] = 8'(wd >> (8 * (nb - 1 - i)));
            end else if (r) begin
                v = 32'd0;
                for (int i = 0; i < nb; i++)
                    v = (v << 8) | 32'(mdl[a + i]);
                if (!lu && nb < 4 && v[8 * nb - 1])
                    v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                mdl_rd = v;
            end
        end
        e.rd  = mdl_rd;
        e.mis = mis;
        e.oor = oor;
        e.cyc = stamp + WS + 1;
        q.push_back(e);
    endtask

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic lu);
        @(negedge clk);
        memread       = r;
        memwrite      = w;
        addr          = a;
        write_data    = wd;
        size          = sz;
        load_unsigned = lu;
        model_req(r, w, a, wd, sz, lu, cyc);
        @(posedge clk);
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        repeat (WS) @(posedge clk);
    endtask

    task automatic ld_expect(input string n, input logic [31:0] a,
                             input logic [1:0] sz, input logic lu,
                             input logic [31:0] exp);
        issue(1'b1, 1'b0, a, 32'd0, sz, lu);
        #1;
        chk(n, read_data, exp);
    endtask

    // Monitor: every completion pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_read_data", read_data, e.rd);
                chk("sb_misaligned", 32'(misaligned), 32'(e.mis));
                chk("sb_out_of_range", 32'(out_of_range), 32'(e.oor));
                chk("sb_latency", cyc, e.cyc);
            end
        end else begin
            chk("flags_without_ready",
                32'({misaligned, out_of_range}), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int stamp;
        logic        r;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          k;

        rst = 1'b1;
        addr = 32'd0;
        write_data = 32'd0;
        memread = 1'b0;
        memwrite = 1'b0;
        size = 2'b00;
        load_unsigned = 1'b0;
        mdl_rd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd0);
            chk("idle_read_data", read_data, 32'd0);
        end

        for (int i = 0; i < DEPTH / 4; i++)
            issue(1'b0, 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0);

        issue(1'b0, 1'b1, 32'h10, 32'h80FF_1234, 2'd2, 1'b0);
        ld_expect("lw_10",  32'h10, 2'd2, 1'b0, 32'h80FF_1234);
        ld_expect("lbu_10", 32'h10, 2'd0, 1'b1, 32'h0000_0080);
        ld_expect("lb_11",  32'h11, 2'd0, 1'b0, 32'hFFFF_FFFF);
        ld_expect("lh_12",  32'h12, 2'd1, 1'b0, 32'h0000_1234);
        ld_expect("lhu_12", 32'h12, 2'd1, 1'b1, 32'h0000_1234);
        ld_expect("lh_10",  32'h10, 2'd1, 1'b0, 32'hFFFF_80FF);
        ld_expect("lhu_10", 32'h10, 2'd1, 1'b1, 32'h0000_80FF);

        issue(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h21, 32'hAB, 2'd0, 1'b0);
        ld_expect("sb_merge", 32'h20, 2'd2, 1'b0, 32'h00AB_0000);
        issue(1'b0, 1'b1, 32'h22, 32'hC3D4, 2'd1, 1'b0);
        ld_expect("sh_merge", 32'h20, 2'd2, 1'b0, 32'h00AB_C3D4);

        issue(1'b1, 1'b0, 32'h13, 32'd0, 2'd2, 1'b0);
        #1;
        chk("lw_13_misaligned", 32'(misaligned), 32'd1);
        chk("lw_13_rd_held", read_data, 32'h00AB_C3D4);

        issue(1'b0, 1'b1, 32'h3FC, 32'h0102_0304, 2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h3FF, 32'hEEEE, 2'd1, 1'b0);
        #1;
        chk("sh_3ff_oor", 32'(out_of_range), 32'd1);
        ld_expect("top_word_kept", 32'h3FC, 2'd2, 1'b0, 32'h0102_0304);
        ld_expect("lb_3ff", 32'h3FF, 2'd0, 1'b1, 32'h0000_0004);
        issue(1'b1, 1'b0, 32'h3FE, 32'd0, 2'd2, 1'b0);
        #1;
        chk("lw_3fe_oor", 32'(out_of_range), 32'd1);
        chk("lw_3fe_mis", 32'(misaligned), 32'd1);

        issue(1'b1, 1'b0, 32'h20, 32'd0, 2'd3, 1'b0);
        #1;
        chk("size11_misaligned", 32'(misaligned), 32'd1);

        // Request during WAIT is dropped; one held into ready is taken.
        @(negedge clk);
        memread = 1'b1;
        memwrite = 1'b0;
        addr = 32'h10;
        size = 2'd2;
        load_unsigned = 1'b0;
        stamp = cyc;
        model_req(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, stamp);
        @(posedge clk);
        @(negedge clk);
        memread = 1'b0;
        memwrite = 1'b1;
        write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        memwrite = 1'b0;
        memread = 1'b1;
        addr = 32'h14;
        model_req(1'b1, 1'b0, 32'h14, 32'd0, 2'd2, 1'b0, stamp + 3);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        memread = 1'b0;
        repeat (WS) @(posedge clk);
        ld_expect("ignored_store", 32'h10, 2'd2, 1'b0, 32'h80FF_1234);

        issue(1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 2'd2, 1'b0);
        #1;
        chk("both_rd_held", read_data, 32'h80FF_1234);
        ld_expect("both_stored", 32'h40, 2'd2, 1'b0, 32'h5555_AAAA);

        // Reset while a store is waiting abandons it.
        issue(1'b0, 1'b1, 32'h50, 32'h1111_1111, 2'd2, 1'b0);
        @(negedge clk);
        memwrite = 1'b1;
        addr = 32'h50;
        write_data = 32'hCAFE_F00D;
        size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        memwrite = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_rd = 32'd0;
        chk("rst_read_data", read_data, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_ready", 32'(ready), 32'd0);
        end
        issue(1'b1, 1'b0, 32'h50, 32'd0, 2'd2, 1'b0);
        #1;
        chk("rst_no_write", 32'(read_data != 32'hCAFE_F00D), 32'd1);

        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 9);
            r  = (k < 4) || (k >= 8);
            w  = (k >= 4);
            k  = $urandom_range(0, 15);
            sz = (k < 5) ? 2'd0 : (k < 10) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
            k  = $urandom_range(0, 9);
            if (k < 7)
                a = 32'($urandom_range(0, 127));
            else if (k < 9)
                a = 32'(DEPTH - 8 + $urandom_range(0, 9));
            else
                a = $urandom;
            if (sz == 2'd3)
                a = 32'($urandom_range(0, 127));
            issue(r, w, a, $urandom, sz, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
